// File: rtl/exec_sequencer.sv
// Execution sequencer for the single-cycle MIPS core: gates commits for free-run,
// single-step, IN wait, OUT hold and halt. Optional PC breakpoint via `BREAKPOINT_EN.
module exec_sequencer #(
  parameter int unsigned OUT_HOLD = 4,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              btn_pulse,
  input  logic              run_mode,
  input  logic              halt_in,
  input  logic              instr_in,
  input  logic              instr_out,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
  output logic              cpu_en,
  output logic              in_wait,
  output logic              out_hold,
  output logic              halted,
  output logic              bp_hit,
  output logic [31:0]       instr_count
);

  localparam int unsigned HOLD_W = (OUT_HOLD > 1) ? $clog2(OUT_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (OUT_HOLD > 0) ? HOLD_W'(OUT_HOLD - 1) : '0;

  typedef enum logic [2:0] {
    IDLE, DECODE, COMMIT, WAIT_IN, HOLD_OUT, BREAK, HALT
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;

`ifdef BREAKPOINT_EN
  logic skip;
  logic bp_match;
  assign bp_match = bp_en && (pc == bp_addr) && !skip;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc};
  assign bp_hit    = 1'b0;
`endif

  // Outputs are registered alongside the state they decode.
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      cpu_en      <= 1'b0;
      in_wait     <= 1'b0;
      out_hold    <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
`ifdef BREAKPOINT_EN
      skip        <= 1'b0;
      bp_hit      <= 1'b0;
`endif
    end else begin
      cpu_en   <= 1'b0;
      in_wait  <= 1'b0;
      out_hold <= 1'b0;
`ifdef BREAKPOINT_EN
      bp_hit   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (run_mode || btn_pulse) state <= DECODE;
        end
        DECODE: begin
          if (halt_in) begin
            state  <= HALT;
            halted <= 1'b1;
`ifdef BREAKPOINT_EN
          end else if (bp_match) begin
            state  <= BREAK;
            bp_hit <= 1'b1;
`endif
          end else if (instr_in) begin
            state   <= WAIT_IN;
            in_wait <= 1'b1;
          end else begin
            state  <= COMMIT;
            cpu_en <= 1'b1;
          end
        end
        WAIT_IN: begin
          if (btn_pulse) begin
            state  <= COMMIT;
            cpu_en <= 1'b1;
          end else begin
            in_wait <= 1'b1;
          end
        end
        COMMIT: begin
          instr_count <= instr_count + 32'd1;
`ifdef BREAKPOINT_EN
          skip        <= 1'b0;
`endif
          if (instr_out && (OUT_HOLD > 0)) begin
            state    <= HOLD_OUT;
            hold_cnt <= HOLD_LOAD;
            out_hold <= 1'b1;
          end else begin
            state <= run_mode ? DECODE : IDLE;
          end
        end
        HOLD_OUT: begin
          if (hold_cnt == '0) begin
            state <= run_mode ? DECODE : IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            out_hold <= 1'b1;
          end
        end
`ifdef BREAKPOINT_EN
        // A press resumes with the breakpoint masked for exactly one commit.
        BREAK: begin
          if (btn_pulse) begin
            skip  <= 1'b1;
            state <= DECODE;
          end else begin
            bp_hit <= 1'b1;
          end
        end
`endif
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
